// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready pipeline stage with synchronous flush, occupancy
// reporting and a saturating stall-cycle counter.
// Build option: define PIPE_STAGE_SKID_EN to add the skid register.
// With the skid register, in_ready comes only from registered state.
// Without it, the stage holds one entry and in_ready is combinational.
module pipe_stage_elastic #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  // The state value is the number of held entries.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   main_q, main_d;
  logic [CNT_W-1:0]   stall_q, stall_d;
`ifdef PIPE_STAGE_SKID_EN
  logic [WIDTH-1:0]   skid_q, skid_d;
`endif

  assign out_valid = (state_q != EMPTY);
  assign occupancy = state_q;
  assign out_data  = main_q;
  assign stall_cnt = stall_q;

`ifdef PIPE_STAGE_SKID_EN
  assign in_ready = (state_q != FULL);
`else
  assign in_ready = out_ready | ~out_valid;
`endif

  // Next-state, payload and stall-counter computation.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    stall_d = stall_q;
`ifdef PIPE_STAGE_SKID_EN
    skid_d  = skid_q;
`endif

    // Stall cycles are counted even while flushing.
    if (out_valid && !out_ready && (stall_q != '1)) begin
      stall_d = stall_q + CNT_W'(1);
    end

    if (flush) begin
      // Any upstream payload offered this cycle is dropped.
      state_d = EMPTY;
      main_d  = '0;
`ifdef PIPE_STAGE_SKID_EN
      skid_d  = '0;
`endif
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_valid) begin
            main_d  = in_data;
            state_d = ONE;
          end
        end
        ONE: begin
          if (out_ready) begin
            if (in_valid) begin
              main_d = in_data;
            end else begin
              state_d = EMPTY;
            end
          end else if (in_valid) begin
`ifdef PIPE_STAGE_SKID_EN
            skid_d  = in_data;
            state_d = FULL;
`endif
          end
        end
        FULL: begin
`ifdef PIPE_STAGE_SKID_EN
          if (out_ready) begin
            main_d  = skid_q;
            state_d = ONE;
          end
`else
          state_d = EMPTY;
`endif
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State, payload and counter registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      stall_q <= '0;
`ifdef PIPE_STAGE_SKID_EN
      skid_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      stall_q <= stall_d;
`ifdef PIPE_STAGE_SKID_EN
      skid_q  <= skid_d;
`endif
    end
  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic: table-driven streaming vectors
// plus hand-written backpressure, flush, async-reset and saturation sequences.
// Expectations adapt to whether PIPE_STAGE_SKID_EN is defined.
module tb_pipe_stage_elastic;

`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic [1:0]  occupancy;
  logic [3:0]  stall_cnt;

  int unsigned passed;
  int unsigned total;

  pipe_stage_elastic #(
    .WIDTH(32),
    .CNT_W(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .occupancy(occupancy),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;
    logic        exp_valid;
    logic        chk_data;
    logic [31:0] exp_data;
    logic [1:0]  exp_occ;
    logic        exp_in_ready;
    logic [3:0]  exp_stall;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    passed    = 0;
    total     = 0;
    rst_n     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Streaming 0x11..0x18, then drain, then load 0xA.
    for (int i = 0; i < 8; i++) begin
      vecs[i] = '{1'b0, 1'b1, 32'h11 + 32'(i), 1'b1, 1'b1, 1'b1, 32'h11 + 32'(i), 2'd1, 1'b1, 4'd0};
    end
    vecs[8] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 2'd0, 1'b1, 4'd0};
    vecs[9] = '{1'b0, 1'b1, 32'hA, 1'b1, 1'b1, 1'b1, 32'hA, 2'd1, 1'b1, 4'd0};

    // Reset state.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      flush     = vecs[i].flush;
      in_valid  = vecs[i].in_valid;
      in_data   = vecs[i].in_data;
      out_ready = vecs[i].out_ready;
      tick();
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].chk_data) chk($sformatf("vec%0d_out_data", i), out_data, vecs[i].exp_data);
      chk($sformatf("vec%0d_occ", i), 32'(occupancy), 32'(vecs[i].exp_occ));
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].exp_in_ready));
      chk($sformatf("vec%0d_stall", i), 32'(stall_cnt), 32'(vecs[i].exp_stall));
    end

    // Backpressure: main=0xA, offer 0xB while out_ready is low.
    in_valid  = 1'b1;
    in_data   = 32'hB;
    out_ready = 1'b0;
    #1;
    chk("bp_in_ready_pre", 32'(in_ready), SKID ? 32'd1 : 32'd0);
    tick();
    chk("bp1_occ", 32'(occupancy), SKID ? 32'd2 : 32'd1);
    chk("bp1_in_ready", 32'(in_ready), 32'd0);
    chk("bp1_out_data", out_data, 32'hA);
    chk("bp1_stall", 32'(stall_cnt), 32'd1);
    for (int k = 2; k <= 4; k++) begin
      tick();
      chk($sformatf("bp%0d_out_data", k), out_data, 32'hA);
      chk($sformatf("bp%0d_occ", k), 32'(occupancy), SKID ? 32'd2 : 32'd1);
      chk($sformatf("bp%0d_stall", k), 32'(stall_cnt), 32'(k));
    end
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_release", 32'(in_ready), SKID ? 32'd0 : 32'd1);
    chk("bp_take_a", out_data, 32'hA);
    tick();
    chk("bp5_out_data", out_data, 32'hB);
    chk("bp5_occ", 32'(occupancy), 32'd1);
    chk("bp5_stall", 32'(stall_cnt), 32'd4);
    in_valid = 1'b0;
    tick();
    chk("bp6_out_valid", 32'(out_valid), 32'd0);
    chk("bp6_occ", 32'(occupancy), 32'd0);

    // Flush while full: main=0x5, skid=0x6, flush with 0x7 offered.
    in_valid  = 1'b1;
    in_data   = 32'h5;
    out_ready = 1'b0;
    tick();
    chk("fl1_occ", 32'(occupancy), 32'd1);
    chk("fl1_stall", 32'(stall_cnt), 32'd4);
    in_data = 32'h6;
    tick();
    chk("fl2_occ", 32'(occupancy), SKID ? 32'd2 : 32'd1);
    chk("fl2_out_data", out_data, 32'h5);
    chk("fl2_stall", 32'(stall_cnt), 32'd5);
    in_data = 32'h7;
    flush   = 1'b1;
    tick();
    chk("fl3_occ", 32'(occupancy), 32'd0);
    chk("fl3_out_valid", 32'(out_valid), 32'd0);
    chk("fl3_in_ready", 32'(in_ready), 32'd1);
    chk("fl3_out_data", out_data, 32'd0);
    chk("fl3_stall", 32'(stall_cnt), 32'd6);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("fl_post%0d_out_valid", k), 32'(out_valid), 32'd0);
    end

    // Asynchronous reset between edges while stalled.
    in_valid  = 1'b1;
    in_data   = 32'h21;
    out_ready = 1'b0;
    tick();
    chk("ar1_occ", 32'(occupancy), 32'd1);
    in_data = 32'h22;
    tick();
    chk("ar2_occ", 32'(occupancy), SKID ? 32'd2 : 32'd1);
    chk("ar2_stall", 32'(stall_cnt), 32'd7);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_out_valid", 32'(out_valid), 32'd0);
    chk("ar_occ", 32'(occupancy), 32'd0);
    chk("ar_stall", 32'(stall_cnt), 32'd0);
    chk("ar_in_ready", 32'(in_ready), 32'd1);
    chk("ar_out_data", out_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Stall counter saturation at 4'hF.
    in_valid  = 1'b1;
    in_data   = 32'h33;
    out_ready = 1'b0;
    tick();
    chk("sat0_stall", 32'(stall_cnt), 32'd0);
    in_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 14) chk("sat14_stall", 32'(stall_cnt), 32'd14);
      if (k == 15) chk("sat15_stall", 32'(stall_cnt), 32'd15);
      if (k == 20) chk("sat20_stall", 32'(stall_cnt), 32'd15);
    end
    chk("sat_out_data", out_data, 32'h33);
    out_ready = 1'b1;
    tick();
    chk("sat_drain_occ", 32'(occupancy), 32'd0);
    chk("sat_drain_stall", 32'(stall_cnt), 32'd15);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
